// File: rtl/can_pkg.sv
// Shared definitions for the CAN receive front end: FSM encoding and stuffing limits.
package can_pkg;

  typedef logic [1:0] can_state_t;

  localparam can_state_t IDLE      = 2'd0;
  localparam can_state_t RECV      = 2'd1;
  localparam can_state_t WAIT_IDLE = 2'd2;

  // Longest legal run of equal bits before a stuff bit must follow.
  localparam int unsigned STUFF_LIMIT    = 5;
  // Recessive samples needed after a frame before a new SOF is accepted.
  localparam int unsigned IDLE_RECESSIVE = 7;

endpackage

// File: rtl/can_destuff.sv
// Bit timer with edge resync, mid-bit sampler and run-length/stuff-bit checker.
module can_destuff
  import can_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10
) (
  input  logic i_Clock,
  input  logic i_Rst_n,
  input  logic i_Rx,        // synchronized line
  input  logic i_Rx_Edge,   // line value changes on the next clock
  input  logic i_Timer_En,  // low holds the timer at 0
  input  logic i_Start,     // SOF seen: restart the run-length tracker
  input  logic i_Check_En,  // stuff checking active (frame being received)
  output logic o_Sample,
  output logic o_Bit,
  output logic o_Stuff,
  output logic o_Error
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST_CNT   = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] SAMPLE_CNT = TW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [2:0]    LIMIT      = 3'(STUFF_LIMIT);

  logic [TW-1:0] timer_q;
  logic [2:0]    run_q;
  logic          last_q;
  logic          at_limit;

  // Bit timer: free-runs over one bit period, restarts on every line edge.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      timer_q <= '0;
    end else if (!i_Timer_En || i_Rx_Edge || (timer_q == LAST_CNT)) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + TW'(1);
    end
  end

  assign at_limit = (run_q == LIMIT);
  assign o_Sample = i_Timer_En && (timer_q == SAMPLE_CNT);
  assign o_Bit    = i_Rx;
  assign o_Stuff  = o_Sample && i_Check_En && at_limit && (i_Rx != last_q);
  assign o_Error  = o_Sample && i_Check_En && at_limit && (i_Rx == last_q);

  // Run-length tracker: counts equal consecutive sampled bits, a stuff bit opens a new run.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      run_q  <= '0;
      last_q <= 1'b0;
    end else if (i_Start) begin
      // last = 0 so the SOF sample itself opens a run of length 1
      run_q  <= '0;
      last_q <= 1'b0;
    end else if (o_Sample && i_Check_En) begin
      if (o_Stuff) begin
        run_q <= 3'd1;
      end else if (!at_limit) begin
        run_q <= (i_Rx == last_q) ? run_q + 3'd1 : 3'd1;
      end
      last_q <= i_Rx;
    end
  end

endmodule

// File: rtl/can_rx_destuff.sv
// CAN receive front end: synchronizes the RX line, destuffs sampled bits into a frame register.
module can_rx_destuff
  import can_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned FRAME_BITS   = 500
) (
  input  logic                  i_Clock,
  input  logic                  i_Rst_n,
  input  logic                  i_Rx_Serial,
  output logic                  o_Ignora_Bit,
  output logic                  o_Eror_Stuffing,
  output logic                  o_Rx_DV,
  output logic [0:FRAME_BITS-1] o_Rx_Byte
);

  localparam int unsigned IW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(FRAME_BITS - 1);
  localparam logic [2:0]    IDLE_LAST = 3'(IDLE_RECESSIVE - 1);

  logic                  rx_meta_q, rx_q;
  logic                  rx_edge, sof;
  can_state_t            state_q, state_d;
  logic [IW-1:0]         index_q, index_d;
  logic [2:0]            idle_cnt_q, idle_cnt_d;
  logic [0:FRAME_BITS-1] frame_d;
  logic                  ign_d, err_d, dv_d;
  logic                  sample, samp_bit, stuff, stuff_err;

  // Two-flop synchronizer, idles recessive.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_meta_q <= 1'b1;
      rx_q      <= 1'b1;
    end else begin
      rx_meta_q <= i_Rx_Serial;
      rx_q      <= rx_meta_q;
    end
  end

  // Looking one stage ahead lets the timer read 0 in the first cycle rx shows a new level.
  assign rx_edge = (rx_meta_q != rx_q);
  assign sof     = (state_q == IDLE) && rx_q && !rx_meta_q;

  can_destuff #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_destuff (
    .i_Clock   (i_Clock),
    .i_Rst_n   (i_Rst_n),
    .i_Rx      (rx_q),
    .i_Rx_Edge (rx_edge),
    .i_Timer_En(state_q != IDLE),
    .i_Start   (sof),
    .i_Check_En(state_q == RECV),
    .o_Sample  (sample),
    .o_Bit     (samp_bit),
    .o_Stuff   (stuff),
    .o_Error   (stuff_err)
  );

  // Frame FSM: collect destuffed bits, then wait for the bus to go idle.
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    idle_cnt_d = idle_cnt_q;
    frame_d    = o_Rx_Byte;
    ign_d      = 1'b0;
    err_d      = 1'b0;
    dv_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (sof) begin
          frame_d = '0;
          index_d = '0;
          state_d = RECV;
        end
      end
      RECV: begin
        if (sample) begin
          // Stuff check takes priority, so a stuff bit never lands in the frame.
          if (stuff) begin
            ign_d = 1'b1;
          end else if (stuff_err) begin
            err_d      = 1'b1;
            idle_cnt_d = '0;
            state_d    = WAIT_IDLE;
          end else begin
            frame_d[index_q] = samp_bit;
            if (index_q == LAST_IDX) begin
              dv_d       = 1'b1;
              idle_cnt_d = '0;
              state_d    = WAIT_IDLE;
            end else begin
              index_d = index_q + IW'(1);
            end
          end
        end
      end
      WAIT_IDLE: begin
        if (sample) begin
          if (samp_bit) begin
            if (idle_cnt_q == IDLE_LAST) begin
              state_d = IDLE;
            end
            idle_cnt_d = idle_cnt_q + 3'd1;
          end else begin
            idle_cnt_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, frame register and one-cycle status pulses.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q         <= IDLE;
      index_q         <= '0;
      idle_cnt_q      <= '0;
      o_Rx_Byte       <= '0;
      o_Ignora_Bit    <= 1'b0;
      o_Eror_Stuffing <= 1'b0;
      o_Rx_DV         <= 1'b0;
    end else begin
      state_q         <= state_d;
      index_q         <= index_d;
      idle_cnt_q      <= idle_cnt_d;
      o_Rx_Byte       <= frame_d;
      o_Ignora_Bit    <= ign_d;
      o_Eror_Stuffing <= err_d;
      o_Rx_DV         <= dv_d;
    end
  end

endmodule

// File: tb/tb_can_rx_destuff.sv
// Bench for can_rx_destuff: two instances (16- and 8-bit frames) share one RX line.
module tb_can_rx_destuff;

  localparam int CPB    = 10;
  localparam int EV_IGN = 1;
  localparam int EV_ERR = 2;
  localparam int EV_DV  = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic rx_line;

  always #5 clk = ~clk;

  logic        ign16, err16, dv16;
  logic [0:15] byte16;
  logic        ign8, err8, dv8;
  logic [0:7]  byte8;

  can_rx_destuff #(.CLKS_PER_BIT(CPB), .FRAME_BITS(16)) u_dut16 (
    .i_Clock        (clk),
    .i_Rst_n        (rst_n),
    .i_Rx_Serial    (rx_line),
    .o_Ignora_Bit   (ign16),
    .o_Eror_Stuffing(err16),
    .o_Rx_DV        (dv16),
    .o_Rx_Byte      (byte16)
  );

  can_rx_destuff #(.CLKS_PER_BIT(CPB), .FRAME_BITS(8)) u_dut8 (
    .i_Clock        (clk),
    .i_Rst_n        (rst_n),
    .i_Rx_Serial    (rx_line),
    .o_Ignora_Bit   (ign8),
    .o_Eror_Stuffing(err8),
    .o_Rx_DV        (dv8),
    .o_Rx_Byte      (byte8)
  );

  int total = 0;
  int bad   = 0;

  // Observed events (per instance) and frame snapshots taken at o_Rx_DV.
  int          obs0[$], obs1[$];
  logic [15:0] snap0[$], snap1[$];

  // Bit-level model: one entry per transmitted bit, applying the destuffing rules directly.
  int          exp0[$], exp1[$];
  logic [15:0] esnap0[$], esnap1[$];
  int          mst[2];    // 0 idle, 1 receiving, 2 waiting for idle
  int          mrun[2], midx[2], mrec[2];
  bit          mlast[2];
  bit          mf[2][16];
  int          nb[2] = '{16, 8};
  bit          mprev;

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic [15:0] pack(input int k);
    logic [15:0] v = '0;
    for (int i = 0; i < nb[k]; i++) v = {v[14:0], mf[k][i]};
    return v;
  endfunction

  task automatic push_exp(input int k, input int ev);
    if (k == 0) begin
      exp0.push_back(ev);
      if (ev == EV_DV) esnap0.push_back(pack(0));
    end else begin
      exp1.push_back(ev);
      if (ev == EV_DV) esnap1.push_back(pack(1));
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mst[k] = 0; mrun[k] = 0; midx[k] = 0; mrec[k] = 0; mlast[k] = 1'b0;
      for (int i = 0; i < 16; i++) mf[k][i] = 1'b0;
    end
    mprev = 1'b1;
  endtask

  task automatic model_bit(input int k, input bit b);
    if (mst[k] == 0 && b == 1'b0 && mprev == 1'b1) begin
      for (int i = 0; i < 16; i++) mf[k][i] = 1'b0;
      midx[k] = 0; mrun[k] = 0; mlast[k] = 1'b0; mst[k] = 1;
    end
    if (mst[k] == 1) begin
      if (mrun[k] == 5 && b != mlast[k]) begin
        push_exp(k, EV_IGN);
        mrun[k] = 1; mlast[k] = b;
      end else if (mrun[k] == 5) begin
        push_exp(k, EV_ERR);
        mst[k] = 2; mrec[k] = 0;
      end else begin
        mf[k][midx[k]] = b;
        midx[k]++;
        mrun[k]  = (b == mlast[k]) ? mrun[k] + 1 : 1;
        mlast[k] = b;
        if (midx[k] == nb[k]) begin
          push_exp(k, EV_DV);
          mst[k] = 2; mrec[k] = 0;
        end
      end
    end else if (mst[k] == 2) begin
      if (b) begin
        mrec[k]++;
        if (mrec[k] == 7) mst[k] = 0;
      end else begin
        mrec[k] = 0;
      end
    end
  endtask

  task automatic send_bit(input bit b, input int len);
    model_bit(0, b);
    model_bit(1, b);
    mprev   = b;
    rx_line = b;
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [15:0] bits, input int n, input bit stretch);
    for (int i = 0; i < n; i++)
      send_bit(bits[n-1-i], stretch ? ((i % 2 == 1) ? 11 : 9) : CPB);
  endtask

  task automatic send_idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1, CPB);
  endtask

  task automatic check_test(input string name);
    cmp({name, "_events16_count"}, obs0.size(), exp0.size());
    if (obs0.size() == exp0.size())
      foreach (exp0[i]) cmp({name, "_event16"}, obs0[i], exp0[i]);
    cmp({name, "_events8_count"}, obs1.size(), exp1.size());
    if (obs1.size() == exp1.size())
      foreach (exp1[i]) cmp({name, "_event8"}, obs1[i], exp1[i]);
    if (snap0.size() == esnap0.size())
      foreach (esnap0[i]) cmp({name, "_dv_frame16"}, snap0[i], esnap0[i]);
    if (snap1.size() == esnap1.size())
      foreach (esnap1[i]) cmp({name, "_dv_frame8"}, snap1[i], esnap1[i]);
    cmp({name, "_held_frame16"}, byte16, pack(0));
    cmp({name, "_held_frame8"}, {8'h00, byte8}, pack(1));
    obs0.delete(); obs1.delete(); snap0.delete(); snap1.delete();
    exp0.delete(); exp1.delete(); esnap0.delete(); esnap1.delete();
  endtask

  // Per-cycle monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      total++;
      if ({ign16, err16, dv16, ign8, err8, dv8} !== 6'b0 || byte16 !== 16'h0 || byte8 !== 8'h0)
      begin
        bad++;
        $display("FAIL reset_outputs: got pulses=%b frame16=%h frame8=%h want all 0",
                 {ign16, err16, dv16, ign8, err8, dv8}, byte16, byte8);
      end
    end else begin
      if (ign16 | err16 | dv16) begin
        total++;
        if (int'(ign16) + int'(err16) + int'(dv16) > 1) begin
          bad++;
          $display("FAIL exclusive16: got ign/err/dv=%b want one-hot", {ign16, err16, dv16});
        end
        if (ign16) obs0.push_back(EV_IGN);
        else if (err16) obs0.push_back(EV_ERR);
        else begin
          obs0.push_back(EV_DV);
          snap0.push_back(byte16);
        end
      end
      if (ign8 | err8 | dv8) begin
        total++;
        if (int'(ign8) + int'(err8) + int'(dv8) > 1) begin
          bad++;
          $display("FAIL exclusive8: got ign/err/dv=%b want one-hot", {ign8, err8, dv8});
        end
        if (ign8) obs1.push_back(EV_IGN);
        else if (err8) obs1.push_back(EV_ERR);
        else begin
          obs1.push_back(EV_DV);
          snap1.push_back({8'h00, byte8});
        end
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    rx_line = 1'b1;
    model_reset();
    #1;
    // Reset held while the line toggles.
    for (int i = 0; i < 30; i++) begin
      rx_line = ~rx_line;
      @(posedge clk);
      #1;
    end
    rx_line = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_idle(5);
    check_test("idle");

    // Alternating bits, no stuffing.
    send_frame(16'b0101010101010101, 16, 1'b0);
    send_idle(20);
    cmp("pin_alt_model16", pack(0), 16'h5555);
    cmp("pin_alt_model8", pack(1), 16'h0055);
    check_test("alt");

    // Stuff bit after five dominant bits.
    send_frame(16'b0000011011, 10, 1'b0);
    send_idle(20);
    cmp("pin_stuff_model8", pack(1), 16'h0005);
    cmp("pin_stuff_events8", exp1.size(), 2);
    check_test("stuff");

    // Six dominant bits: stuffing violation.
    send_frame(16'b000000, 6, 1'b0);
    send_idle(20);
    cmp("pin_err_events16", exp0.size(), 1);
    check_test("stuff_err");

    // Bits alternately 9 and 11 cycles long.
    send_frame(16'b0110100110010110, 16, 1'b1);
    send_idle(20);
    cmp("pin_stretch_model16", pack(0), 16'h6996);
    cmp("pin_stretch_model8", pack(1), 16'h0069);
    check_test("stretch");

    // Reset in the middle of a frame, then a fresh frame.
    send_frame(16'b01101, 5, 1'b0);
    rst_n   = 1'b0;
    rx_line = 1'b1;
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    cmp("after_reset_frame16_clear", byte16, 16'h0);
    @(posedge clk);
    #1;
    send_idle(2);
    send_frame(16'h3C5A, 16, 1'b0);
    send_idle(20);
    cmp("pin_reset_model16", pack(0), 16'h3C5A);
    check_test("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
